// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl RAM initiator: FSM state encoding,
// default bus widths and the RAM read latency seen by the controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ1 = 2'd2,
        READ2 = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_W   = 7;
    localparam int unsigned DEF_DATA_W   = 8;

    // Cycles between read accept and the edge at which saida is captured.
    localparam int unsigned READ_LATENCY = 2;

endpackage

// File: rtl/mem_ram.sv
// mem_ram: 8-bit data RAM driven by mem_ctrl.
// Write port samples on posedge; the read port registers the address on a
// negedge and presents the data on the following negedge (two-stage read).
module mem_ram #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              escrita,
    input  logic [ADDR_W-1:0] end_entrada,
    input  logic [DATA_W-1:0] entrada,
    input  logic [ADDR_W-1:0] end_saida,
    output logic [DATA_W-1:0] saida
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] read_addr;

    // Write port: commit on the rising edge while escrita is high.
    always_ff @(posedge clk) begin
        if (escrita) begin
            mem[end_entrada] <= entrada;
        end
    end

    // Read port: address captured one negedge, data driven on the next.
    always_ff @(negedge clk) begin
        read_addr <= end_saida;
        saida     <= mem[read_addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: initiator-side controller for mem_ram.
// Accepts single read/write requests over valid/ready, hides the RAM's
// negedge read latency and returns exactly one resp_valid pulse per request.
// Optional feature: MEM_CTRL_RANGE_CHECK_EN -- requests with
// req_addr >= DEPTH complete immediately with resp_err=1 and no RAM access.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              escrita,
    output logic [ADDR_W-1:0] end_entrada,
    output logic [DATA_W-1:0] entrada,
    output logic [ADDR_W-1:0] end_saida,
    input  logic [DATA_W-1:0] saida
);

    state_t            state, state_d;
    logic              escrita_d;
    logic [ADDR_W-1:0] end_entrada_d;
    logic [DATA_W-1:0] entrada_d;
    logic [ADDR_W-1:0] end_saida_d;
    logic              resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_d;
    logic              resp_err_d;
    logic              range_err;

`ifdef MEM_CTRL_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];
    assign range_err = ({1'b0, req_addr} >= DEPTH_LIM);
`else
    // Without range checking every address goes to the RAM.
    logic unused_depth;
    assign unused_depth = ^DEPTH;
    assign range_err    = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            escrita     <= 1'b0;
            end_entrada <= '0;
            entrada     <= '0;
            end_saida   <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state       <= state_d;
            escrita     <= escrita_d;
            end_entrada <= end_entrada_d;
            entrada     <= entrada_d;
            end_saida   <= end_saida_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
        end
    end

    // Next-state and next-output logic; addresses/data hold unless reloaded.
    always_comb begin
        state_d       = state;
        escrita_d     = 1'b0;
        end_entrada_d = end_entrada;
        entrada_d     = entrada;
        end_saida_d   = end_saida;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata;
        resp_err_d    = 1'b0;

        case (state)
            IDLE: begin
                // req_ready is high here, so req_valid means an accept.
                if (req_valid) begin
                    if (range_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d       = WRITE;
                        escrita_d     = 1'b1;
                        end_entrada_d = req_addr;
                        entrada_d     = req_wdata;
                    end else begin
                        state_d     = READ1;
                        end_saida_d = req_addr;
                    end
                end
            end
            WRITE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            READ1: begin
                state_d = READ2;
            end
            READ2: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = saida;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
